airi5c_wb_stage: RTL and testbench
==================================

# airi5c_wb_stage

Writeback-stage controller of the AIRI5C pipeline, directly downstream of the EX/WB pipeline registers. It consumes the instruction currently in WB, waits for data-memory or PCPI completion, and aligns and extends load data. It drives the register-file write port, retire and fault pulses, and the `stall_WB` signal that freezes the EX/WB registers.

## Interface
- `XPR_LEN`, 32: datapath width.
- `PCPI_TIMEOUT`, 16: cycles to wait for `pcpi_ready` before faulting. Range 2..255.
- `clk` in 1: clock.
- `nreset` in 1: reset, asynchronous, active-low.
- `valid_WB` in 1: a non-bubble instruction is present in WB.
- `prev_killed_WB` in 1: the WB instruction was killed upstream.
- `had_ex_WB` in 1: the WB instruction already raised an exception.
- `wb_src_sel_WB` in 2: result select. 0 = ALU, 1 = memory, 2 = CSR, 3 = PCPI.
- `wr_reg_WB` in 1: the instruction writes rd.
- `reg_to_wr_WB` in 5: rd address.
- `alu_out_WB` in XPR_LEN: ALU result.
- `csr_rdata_WB` in XPR_LEN: CSR read data.
- `dmem_en_WB` in 1: memory access.
- `store_in_WB` in 1: the access is a store.
- `dmem_size_WB` in 2: access size. 0 = byte, 1 = half, 2 = word.
- `dmem_unsigned_WB` in 1: zero-extend the load.
- `dmem_addr_lo_WB` in 2: address bits [1:0].
- `dmem_rvalid` in 1: memory response or acknowledge.
- `dmem_rdata` in XPR_LEN: memory read data.
- `dmem_error` in 1: bus error, qualified by `dmem_rvalid`.
- `uses_pcpi_WB`, `pcpi_ready`, `pcpi_wr` in 1 each: PCPI handshake. Only used with `AIRI5C_WB_PCPI_EN`.
- `pcpi_rd` in XPR_LEN: PCPI result.
- `stall_WB` out 1: hold the EX/WB registers.
- `rf_wen` out 1: register-file write enable.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out XPR_LEN: register-file write data.
- `retire` out 1: one-cycle pulse when an instruction completes without a fault.
- `wb_fault` out 1: one-cycle fault pulse.
- `wb_fault_code` out 4: mcause code for the fault.

## Operation
- The block has three states: IDLE, WAIT_MEM and WAIT_PCPI.
- **IDLE, no valid instruction, or `prev_killed_WB`, or `had_ex_WB`:** no write, no retire, no fault, `stall_WB`=0. Any `dmem_rvalid` is ignored; upstream never issues killed accesses.
- **IDLE, `dmem_en_WB`:**
  - If `dmem_rvalid` is high in the same cycle, complete immediately.
  - Otherwise set `stall_WB`=1 and go to WAIT_MEM.
- **WAIT_MEM:** hold `stall_WB`=1 until `dmem_rvalid`. Complete in that cycle and return to IDLE.
- **IDLE, `uses_pcpi_WB` (macro on):**
  - Load the timeout counter with `PCPI_TIMEOUT`-1.
  - If `pcpi_ready` is high, complete immediately.
  - Otherwise set `stall_WB`=1 and go to WAIT_PCPI.
- **WAIT_PCPI:** decrement the counter each cycle.
  - `pcpi_ready`: complete and return to IDLE.
  - Counter reaches 0 without `pcpi_ready`: raise a fault with code 2 (illegal instruction), no write, return to IDLE.
  - `pcpi_ready` in the same cycle the counter reaches 0: `pcpi_ready` wins.
- **Other instructions:** complete in the same cycle.
- **Completion:**
  - `stall_WB`=0 and `retire`=1.
  - `rf_wen` = `wr_reg_WB` & (`reg_to_wr_WB`≠0). For PCPI the enable is additionally gated by `pcpi_wr`.
  - `rf_waddr` = `reg_to_wr_WB`.
- **Memory error on completion:** `dmem_rvalid`&`dmem_error` gives no write and no retire. `wb_fault`=1 with code 5 for a load, 7 for a store.
- **Load alignment:**
  - Byte: select `dmem_rdata[8*addr_lo+7 : 8*addr_lo]`.
  - Half: use `addr_lo[1]`; `addr_lo[0]` is ignored.
  - Word: `addr_lo` is ignored.
  - Extension is sign or zero per `dmem_unsigned_WB`.
- **Stores** never write the register file.
- **Write-data mux:** select `rf_wdata` by `wb_src_sel_WB`. It is 0 when `rf_wen`=0.

## Timing
- Reset values: state IDLE, counter 0. All outputs are combinational, so with IDLE and no valid input every output is 0.
- Zero-latency path: completion falls in the same cycle as the response. `stall_WB` is deasserted in that cycle, so EX/WB loads the next instruction at the following edge.
- `stall_WB` is a combinational function of the state, the WB inputs and `dmem_rvalid`/`pcpi_ready`.
- WB inputs are stable while `stall_WB`=1.
- Reset mid-wait: return to IDLE immediately. Any response arriving after reset is ignored.
- At most one outstanding memory access. `dmem_rvalid` in IDLE with no `dmem_en_WB` is ignored.

## Configuration
- `AIRI5C_WB_PCPI_EN` defined: WAIT_PCPI, the timeout counter and PCPI result select are built.
- Undefined:
  - PCPI inputs are unused.
  - `uses_pcpi_WB` is treated as 0.
  - Select 3 yields 0.
  - The state register holds only IDLE and WAIT_MEM.

## Structure
- Package constants: state encoding, `wb_src_sel` codes, and mcause codes 2, 5 and 7 (shared with the control constants header).
- One sub-module, `airi5c_load_align`: a combinational byte/half/word select plus extension.

## Test plan
- ALU op, rd=5, `alu_out`=0x1234, no memory: `rf_wen`=1, `rf_wdata`=0x1234, `retire`=1, `stall_WB`=0 in the same cycle.
- Byte load, signed, `addr_lo`=2, `rdata`=0x0080FF00, `rvalid` 3 cycles late: `stall_WB`=1 for 3 cycles, then `rf_wdata`=0xFFFFFF80.
- Unsigned half load, `addr_lo`=2, `rdata`=0x8001xxxx: `rf_wdata`=0x00008001. Same load with rd=0: `rf_wen`=0, `retire`=1.
- Store acknowledged with `dmem_error`=1: `wb_fault`=1, code 7, `rf_wen`=0, `retire`=0. Killed load: no stall, no write.
- PCPI (macro on), `PCPI_TIMEOUT`=4, no ready: 3 stall cycles, then fault code 2. Ready at cycle 2 with `pcpi_wr`=1: write `pcpi_rd`.
- Assert `nreset` during WAIT_MEM, then send `rvalid`: no write, state IDLE, `stall_WB`=0.

Source files
------------

// File: rtl/airi5c_wb_stage_pkg.sv
// Shared constants for the AIRI5C writeback stage: state encoding, result selects, access sizes, mcause codes.
// The state type shrinks to two states unless AIRI5C_WB_PCPI_EN is defined.
package airi5c_wb_stage_pkg;

`ifdef AIRI5C_WB_PCPI_EN
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_MEM  = 2'd1,
    ST_WAIT_PCPI = 2'd2
  } wb_state_e;
`else
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;
`endif

  localparam logic [1:0] WB_SRC_ALU  = 2'd0;
  localparam logic [1:0] WB_SRC_MEM  = 2'd1;
  localparam logic [1:0] WB_SRC_CSR  = 2'd2;
  localparam logic [1:0] WB_SRC_PCPI = 2'd3;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  // Must track the control constants header.
  localparam logic [3:0] MCAUSE_ILLEGAL_INST = 4'd2;
  localparam logic [3:0] MCAUSE_LOAD_FAULT   = 4'd5;
  localparam logic [3:0] MCAUSE_STORE_FAULT  = 4'd7;

endpackage

// File: rtl/airi5c_wb_stage_if.sv
// Bundle of EX/WB pipeline, data-memory response, PCPI and register-file signals seen by the WB stage.
// slave = the WB stage, master = the surrounding pipeline / memory / RF.
interface airi5c_wb_stage_if #(
  parameter int XPR_LEN = 32
);
  logic               valid_WB;
  logic               prev_killed_WB;
  logic               had_ex_WB;
  logic [1:0]         wb_src_sel_WB;
  logic               wr_reg_WB;
  logic [4:0]         reg_to_wr_WB;
  logic [XPR_LEN-1:0] alu_out_WB;
  logic [XPR_LEN-1:0] csr_rdata_WB;
  logic               dmem_en_WB;
  logic               store_in_WB;
  logic [1:0]         dmem_size_WB;
  logic               dmem_unsigned_WB;
  logic [1:0]         dmem_addr_lo_WB;
  logic               dmem_rvalid;
  logic [XPR_LEN-1:0] dmem_rdata;
  logic               dmem_error;
  logic               uses_pcpi_WB;
  logic               pcpi_ready;
  logic               pcpi_wr;
  logic [XPR_LEN-1:0] pcpi_rd;

  logic               stall_WB;
  logic               rf_wen;
  logic [4:0]         rf_waddr;
  logic [XPR_LEN-1:0] rf_wdata;
  logic               retire;
  logic               wb_fault;
  logic [3:0]         wb_fault_code;

  modport slave (
    input  valid_WB, prev_killed_WB, had_ex_WB, wb_src_sel_WB, wr_reg_WB, reg_to_wr_WB,
           alu_out_WB, csr_rdata_WB, dmem_en_WB, store_in_WB, dmem_size_WB,
           dmem_unsigned_WB, dmem_addr_lo_WB, dmem_rvalid, dmem_rdata, dmem_error,
           uses_pcpi_WB, pcpi_ready, pcpi_wr, pcpi_rd,
    output stall_WB, rf_wen, rf_waddr, rf_wdata, retire, wb_fault, wb_fault_code
  );

  modport master (
    output valid_WB, prev_killed_WB, had_ex_WB, wb_src_sel_WB, wr_reg_WB, reg_to_wr_WB,
           alu_out_WB, csr_rdata_WB, dmem_en_WB, store_in_WB, dmem_size_WB,
           dmem_unsigned_WB, dmem_addr_lo_WB, dmem_rvalid, dmem_rdata, dmem_error,
           uses_pcpi_WB, pcpi_ready, pcpi_wr, pcpi_rd,
    input  stall_WB, rf_wen, rf_waddr, rf_wdata, retire, wb_fault, wb_fault_code
  );
endinterface

// File: rtl/airi5c_wb_stage_load_align.sv
// Load data alignment: picks the byte/half/word lane out of the bus word and sign/zero extends it.
module airi5c_load_align
  import airi5c_wb_stage_pkg::*;
#(
  parameter int XPR_LEN = 32
) (
  input  logic [XPR_LEN-1:0] rdata,
  input  logic [1:0]         size,
  input  logic               is_unsigned,
  input  logic [1:0]         addr_lo,
  output logic [XPR_LEN-1:0] data
);

  logic [XPR_LEN-1:0] byte_sh;
  logic [XPR_LEN-1:0] half_sh;
  logic               b_sign;
  logic               h_sign;

  assign byte_sh = rdata >> {addr_lo, 3'b000};
  // Halves are lane-aligned only on addr_lo[1]; bit 0 is a don't-care.
  assign half_sh = rdata >> {addr_lo[1], 4'b0000};
  assign b_sign  = byte_sh[7]  & ~is_unsigned;
  assign h_sign  = half_sh[15] & ~is_unsigned;

  always_comb begin
    data = rdata;
    case (size)
      MEM_SIZE_B: data = {{(XPR_LEN-8){b_sign}},  byte_sh[7:0]};
      MEM_SIZE_H: data = {{(XPR_LEN-16){h_sign}}, half_sh[15:0]};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/airi5c_wb_stage.sv
// AIRI5C writeback-stage controller: waits for dmem/PCPI completion, aligns loads, drives RF write, retire and faults.
// Optional PCPI support (WAIT_PCPI state, timeout counter, select 3) is built when AIRI5C_WB_PCPI_EN is defined.
module airi5c_wb_stage
  import airi5c_wb_stage_pkg::*;
#(
  parameter int XPR_LEN      = 32,
  parameter int PCPI_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                nreset,
  airi5c_wb_stage_if.slave    wb
);

  wb_state_e          state_q, state_d;
  logic               active;
  logic               is_mem;
  logic               is_pcpi;
  logic               complete;
  logic               mem_done;
  logic               fault;
  logic [3:0]         fault_code;
  logic               wen;
  logic [XPR_LEN-1:0] load_data;
  logic [XPR_LEN-1:0] wdata;

  assign active = wb.valid_WB & ~wb.prev_killed_WB & ~wb.had_ex_WB;
  assign is_mem = active & wb.dmem_en_WB;

`ifdef AIRI5C_WB_PCPI_EN
  logic [7:0] cnt_q, cnt_d;
  assign is_pcpi = active & ~wb.dmem_en_WB & wb.uses_pcpi_WB;
`else
  assign is_pcpi = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
`ifdef AIRI5C_WB_PCPI_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef AIRI5C_WB_PCPI_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    wb.stall_WB = 1'b0;
    complete   = 1'b0;
    mem_done   = 1'b0;
    fault      = 1'b0;
    fault_code = 4'd0;
`ifdef AIRI5C_WB_PCPI_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          if (wb.dmem_rvalid) mem_done = 1'b1;
          else begin
            wb.stall_WB = 1'b1;
            state_d     = ST_WAIT_MEM;
          end
`ifdef AIRI5C_WB_PCPI_EN
        end else if (is_pcpi) begin
          cnt_d = 8'(PCPI_TIMEOUT - 1);
          if (wb.pcpi_ready) complete = 1'b1;
          else begin
            wb.stall_WB = 1'b1;
            state_d     = ST_WAIT_PCPI;
          end
`endif
        end else if (active) begin
          complete = 1'b1;
        end
      end
      ST_WAIT_MEM: begin
        if (wb.dmem_rvalid) begin
          mem_done = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wb.stall_WB = 1'b1;
        end
      end
`ifdef AIRI5C_WB_PCPI_EN
      ST_WAIT_PCPI: begin
        cnt_d = cnt_q - 8'd1;
        // Ready wins over a timeout landing in the same cycle.
        if (wb.pcpi_ready) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else if (cnt_q <= 8'd1) begin
          fault      = 1'b1;
          fault_code = MCAUSE_ILLEGAL_INST;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          wb.stall_WB = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (mem_done) begin
      if (wb.dmem_error) begin
        fault      = 1'b1;
        fault_code = wb.store_in_WB ? MCAUSE_STORE_FAULT : MCAUSE_LOAD_FAULT;
      end else begin
        complete = 1'b1;
      end
    end
  end

  airi5c_load_align #(.XPR_LEN(XPR_LEN)) u_load_align (
    .rdata       (wb.dmem_rdata),
    .size        (wb.dmem_size_WB),
    .is_unsigned (wb.dmem_unsigned_WB),
    .addr_lo     (wb.dmem_addr_lo_WB),
    .data        (load_data)
  );

  always_comb begin
    wen = complete & wb.wr_reg_WB & (wb.reg_to_wr_WB != 5'd0)
        & ~(wb.dmem_en_WB & wb.store_in_WB);
    if (is_pcpi) wen = wen & wb.pcpi_wr;
  end

  always_comb begin
    wdata = '0;
    case (wb.wb_src_sel_WB)
      WB_SRC_ALU:  wdata = wb.alu_out_WB;
      WB_SRC_MEM:  wdata = load_data;
      WB_SRC_CSR:  wdata = wb.csr_rdata_WB;
`ifdef AIRI5C_WB_PCPI_EN
      WB_SRC_PCPI: wdata = wb.pcpi_rd;
`endif
      default:     wdata = '0;
    endcase
  end

  assign wb.rf_wen        = wen;
  assign wb.rf_waddr      = complete ? wb.reg_to_wr_WB : 5'd0;
  assign wb.rf_wdata      = wen ? wdata : '0;
  assign wb.retire        = complete;
  assign wb.wb_fault      = fault;
  assign wb.wb_fault_code = fault_code;

endmodule

// File: tb/tb_airi5c_wb_stage.sv
// Directed self-checking bench for airi5c_wb_stage; PCPI steps run only when AIRI5C_WB_PCPI_EN is defined.
module tb_airi5c_wb_stage;
  import airi5c_wb_stage_pkg::*;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  airi5c_wb_stage_if #(.XPR_LEN(32)) bus ();

  airi5c_wb_stage #(.XPR_LEN(32), .PCPI_TIMEOUT(4)) dut (
    .clk    (clk),
    .nreset (nreset),
    .wb     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.valid_WB = 0; bus.prev_killed_WB = 0; bus.had_ex_WB = 0; bus.wb_src_sel_WB = 0;
    bus.wr_reg_WB = 0; bus.reg_to_wr_WB = 0; bus.alu_out_WB = 0; bus.csr_rdata_WB = 0;
    bus.dmem_en_WB = 0; bus.store_in_WB = 0; bus.dmem_size_WB = 0; bus.dmem_unsigned_WB = 0;
    bus.dmem_addr_lo_WB = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0; bus.dmem_error = 0;
    bus.uses_pcpi_WB = 0; bus.pcpi_ready = 0; bus.pcpi_wr = 0; bus.pcpi_rd = 0;
  endtask

  task automatic step();
    @(negedge clk);
    clr();
  endtask

  task automatic load(input logic [4:0] rd, input logic [1:0] sz, input logic uns,
                      input logic [1:0] lo, input logic [31:0] rdata, input logic rv);
    bus.valid_WB = 1; bus.dmem_en_WB = 1; bus.wb_src_sel_WB = WB_SRC_MEM;
    bus.wr_reg_WB = 1; bus.reg_to_wr_WB = rd; bus.dmem_size_WB = sz;
    bus.dmem_unsigned_WB = uns; bus.dmem_addr_lo_WB = lo; bus.dmem_rdata = rdata;
    bus.dmem_rvalid = rv;
  endtask

  initial begin
    clr();
    #2;
    chk("rst_stall",  {31'd0, bus.stall_WB}, 32'd0);
    chk("rst_wen",    {31'd0, bus.rf_wen},   32'd0);
    chk("rst_retire", {31'd0, bus.retire},   32'd0);
    chk("rst_fault",  {31'd0, bus.wb_fault}, 32'd0);
    chk("rst_wdata",  bus.rf_wdata,          32'd0);
    @(negedge clk); nreset = 1;

    // ALU op
    step();
    bus.valid_WB = 1; bus.wr_reg_WB = 1; bus.reg_to_wr_WB = 5; bus.alu_out_WB = 32'h1234;
    #1;
    chk("alu_wen",    {31'd0, bus.rf_wen},  32'd1);
    chk("alu_waddr",  {27'd0, bus.rf_waddr}, 32'd5);
    chk("alu_wdata",  bus.rf_wdata,          32'h1234);
    chk("alu_retire", {31'd0, bus.retire},  32'd1);
    chk("alu_stall",  {31'd0, bus.stall_WB}, 32'd0);

    // CSR op
    step();
    bus.valid_WB = 1; bus.wr_reg_WB = 1; bus.reg_to_wr_WB = 7;
    bus.wb_src_sel_WB = WB_SRC_CSR; bus.csr_rdata_WB = 32'hCAFE; bus.alu_out_WB = 32'h1;
    #1;
    chk("csr_wdata", bus.rf_wdata, 32'hCAFE);

    // Signed byte load, response three cycles late
    step();
    load(5'd9, MEM_SIZE_B, 1'b0, 2'd2, 32'h0080FF00, 1'b0);
    #1; chk("lb_stall0", {31'd0, bus.stall_WB}, 32'd1);
    chk("lb_retire0", {31'd0, bus.retire}, 32'd0);
    @(negedge clk); #1; chk("lb_stall1", {31'd0, bus.stall_WB}, 32'd1);
    @(negedge clk); #1; chk("lb_stall2", {31'd0, bus.stall_WB}, 32'd1);
    @(negedge clk); bus.dmem_rvalid = 1; #1;
    chk("lb_stall3", {31'd0, bus.stall_WB}, 32'd0);
    chk("lb_wdata",  bus.rf_wdata, 32'hFFFFFF80);
    chk("lb_wen",    {31'd0, bus.rf_wen}, 32'd1);
    chk("lb_retire", {31'd0, bus.retire}, 32'd1);

    // Unsigned half load, same-cycle response
    step();
    load(5'd3, MEM_SIZE_H, 1'b1, 2'd2, 32'h8001ABCD, 1'b1);
    #1;
    chk("lhu_wdata", bus.rf_wdata, 32'h00008001);
    chk("lhu_stall", {31'd0, bus.stall_WB}, 32'd0);
    step();
    load(5'd0, MEM_SIZE_H, 1'b1, 2'd2, 32'h8001ABCD, 1'b1);
    #1;
    chk("lhu_x0_wen",    {31'd0, bus.rf_wen}, 32'd0);
    chk("lhu_x0_retire", {31'd0, bus.retire}, 32'd1);
    chk("lhu_x0_wdata",  bus.rf_wdata, 32'd0);

    // Signed half, odd addr_lo ignored on bit 0; word ignores addr_lo
    step();
    load(5'd4, MEM_SIZE_H, 1'b0, 2'd1, 32'h1234F00D, 1'b1);
    #1; chk("lh_wdata", bus.rf_wdata, 32'hFFFFF00D);
    step();
    load(5'd4, MEM_SIZE_W, 1'b0, 2'd3, 32'hDEADBEEF, 1'b1);
    #1; chk("lw_wdata", bus.rf_wdata, 32'hDEADBEEF);
    step();
    load(5'd4, MEM_SIZE_B, 1'b1, 2'd3, 32'h9A000000, 1'b1);
    #1; chk("lbu_wdata", bus.rf_wdata, 32'h0000009A);

    // Store acknowledged with error
    step();
    bus.valid_WB = 1; bus.dmem_en_WB = 1; bus.store_in_WB = 1; bus.wr_reg_WB = 1;
    bus.reg_to_wr_WB = 6; bus.dmem_rvalid = 1; bus.dmem_error = 1;
    #1;
    chk("st_err_fault",  {31'd0, bus.wb_fault}, 32'd1);
    chk("st_err_code",   {28'd0, bus.wb_fault_code}, 32'd7);
    chk("st_err_wen",    {31'd0, bus.rf_wen}, 32'd0);
    chk("st_err_retire", {31'd0, bus.retire}, 32'd0);

    // Store acknowledged cleanly: retires, never writes
    step();
    bus.valid_WB = 1; bus.dmem_en_WB = 1; bus.store_in_WB = 1; bus.wr_reg_WB = 1;
    bus.reg_to_wr_WB = 6; bus.dmem_rvalid = 1;
    #1;
    chk("st_retire", {31'd0, bus.retire}, 32'd1);
    chk("st_wen",    {31'd0, bus.rf_wen}, 32'd0);

    // Load with error after one wait cycle
    step();
    load(5'd8, MEM_SIZE_W, 1'b0, 2'd0, 32'h0, 1'b0);
    @(negedge clk); bus.dmem_rvalid = 1; bus.dmem_error = 1; #1;
    chk("ld_err_code",  {28'd0, bus.wb_fault_code}, 32'd5);
    chk("ld_err_fault", {31'd0, bus.wb_fault}, 32'd1);
    chk("ld_err_stall", {31'd0, bus.stall_WB}, 32'd0);

    // Killed load, then exception-marked op, then stray rvalid
    step();
    load(5'd8, MEM_SIZE_W, 1'b0, 2'd0, 32'h0, 1'b0);
    bus.prev_killed_WB = 1;
    #1;
    chk("kill_stall", {31'd0, bus.stall_WB}, 32'd0);
    chk("kill_wen",   {31'd0, bus.rf_wen},   32'd0);
    @(negedge clk); #1;
    chk("kill_stall_next", {31'd0, bus.stall_WB}, 32'd0);
    step();
    bus.valid_WB = 1; bus.had_ex_WB = 1; bus.wr_reg_WB = 1; bus.reg_to_wr_WB = 5;
    bus.alu_out_WB = 32'h55;
    #1;
    chk("hadex_retire", {31'd0, bus.retire}, 32'd0);
    chk("hadex_wen",    {31'd0, bus.rf_wen}, 32'd0);
    step();
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h77;
    #1;
    chk("stray_rvalid_retire", {31'd0, bus.retire}, 32'd0);

    // Select 3 on a non-PCPI op
    step();
    bus.valid_WB = 1; bus.wr_reg_WB = 1; bus.reg_to_wr_WB = 2;
    bus.wb_src_sel_WB = WB_SRC_PCPI; bus.pcpi_rd = 32'h600D; bus.alu_out_WB = 32'h1;
    #1;
`ifdef AIRI5C_WB_PCPI_EN
    chk("sel3_wdata", bus.rf_wdata, 32'h600D);
`else
    chk("sel3_wdata", bus.rf_wdata, 32'h0);
`endif

    // Reset during WAIT_MEM, then a late response
    step();
    load(5'd10, MEM_SIZE_W, 1'b0, 2'd0, 32'h1111, 1'b0);
    @(negedge clk); #1;
    chk("rstw_stall_pre", {31'd0, bus.stall_WB}, 32'd1);
    @(negedge clk);
    nreset = 0; clr(); #1;
    chk("rstw_stall", {31'd0, bus.stall_WB}, 32'd0);
    chk("rstw_state", {31'd0, 1'(dut.state_q == ST_IDLE)}, 32'd1);
    @(negedge clk); nreset = 1;
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h1111; #1;
    chk("rstw_wen",    {31'd0, bus.rf_wen}, 32'd0);
    chk("rstw_retire", {31'd0, bus.retire}, 32'd0);
    @(negedge clk); #1;
    chk("rstw_state_after", {31'd0, 1'(dut.state_q == ST_IDLE)}, 32'd1);
    chk("rstw_stall_after", {31'd0, bus.stall_WB}, 32'd0);

`ifdef AIRI5C_WB_PCPI_EN
    // PCPI timeout: three stall cycles, fault on the fourth
    step();
    bus.valid_WB = 1; bus.uses_pcpi_WB = 1; bus.wb_src_sel_WB = WB_SRC_PCPI;
    bus.wr_reg_WB = 1; bus.reg_to_wr_WB = 11; bus.pcpi_wr = 1; bus.pcpi_rd = 32'hBAD;
    #1; chk("pcpi_to_stall0", {31'd0, bus.stall_WB}, 32'd1);
    @(negedge clk); #1; chk("pcpi_to_stall1", {31'd0, bus.stall_WB}, 32'd1);
    @(negedge clk); #1; chk("pcpi_to_stall2", {31'd0, bus.stall_WB}, 32'd1);
    @(negedge clk); #1;
    chk("pcpi_to_stall3", {31'd0, bus.stall_WB}, 32'd0);
    chk("pcpi_to_fault",  {31'd0, bus.wb_fault}, 32'd1);
    chk("pcpi_to_code",   {28'd0, bus.wb_fault_code}, 32'd2);
    chk("pcpi_to_wen",    {31'd0, bus.rf_wen}, 32'd0);
    chk("pcpi_to_retire", {31'd0, bus.retire}, 32'd0);

    // PCPI ready on the second wait cycle
    step();
    bus.valid_WB = 1; bus.uses_pcpi_WB = 1; bus.wb_src_sel_WB = WB_SRC_PCPI;
    bus.wr_reg_WB = 1; bus.reg_to_wr_WB = 12; bus.pcpi_wr = 1; bus.pcpi_rd = 32'hABCD;
    #1; chk("pcpi_rd_stall0", {31'd0, bus.stall_WB}, 32'd1);
    @(negedge clk); #1; chk("pcpi_rd_stall1", {31'd0, bus.stall_WB}, 32'd1);
    @(negedge clk); bus.pcpi_ready = 1; #1;
    chk("pcpi_rd_wen",    {31'd0, bus.rf_wen}, 32'd1);
    chk("pcpi_rd_wdata",  bus.rf_wdata, 32'hABCD);
    chk("pcpi_rd_retire", {31'd0, bus.retire}, 32'd1);
    chk("pcpi_rd_stall",  {31'd0, bus.stall_WB}, 32'd0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
